// File: rtl/parity_pkg.sv
// Shared definitions for the parity scheduler: FSM encoding and datapath width.
package parity_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/parity_core.sv
// Registered XOR-reduce parity engine.
// Build macro PARITY_ODD_EN selects odd parity; default is even parity.
module parity_core
    import parity_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    output logic              parity_out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_out <= 1'b0;
        end else begin
`ifdef PARITY_ODD_EN
            parity_out <= ~^din;
`else
            parity_out <= ^din;
`endif
        end
    end

endmodule

// File: rtl/parity_sched.sv
// Round-robin scheduler sharing one parity_core among NREQ requesters.
// Parity sense follows the PARITY_ODD_EN build macro (see parity_core).
//
// state | meaning
// IDLE  | waiting for a request; rotating-priority grant offered on req_ready
// BUSY  | captured word in the engine, cnt counts down the LAT cycles
// DONE  | response valid, held until resp_ready
module parity_sched
    import parity_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   resp_parity,
    output logic [IDW-1:0]         resp_id,
    output logic                   busy
);

    state_t            state;
    state_t            state_nxt;
    logic [IDW-1:0]    last_grant;
    logic [IDW-1:0]    grant;
    logic              found;
    int                idx;
    logic              any_valid;
    logic              accept;
    logic              finish;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] core_din;
    logic              core_par;

    // Search starts one past the last winner, so service rotates strictly.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                grant = IDW'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_valid = |req_valid;
    assign accept    = (state == S_IDLE) && any_valid;
    assign finish    = (state == S_BUSY) && (cnt == 4'd0);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Feed the engine the incoming word on the accept cycle so its registered
    // output is ready by the time cnt reaches zero, even for LAT=1.
    assign core_din = accept ? req_data[int'(grant)*DATA_W +: DATA_W] : data_q;

    parity_core u_core (
        .clk        (clk),
        .reset      (reset),
        .din        (core_din),
        .parity_out (core_par)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)     state_nxt = S_BUSY;
            S_BUSY:  if (finish)     state_nxt = S_DONE;
            S_DONE:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant  <= IDW'(NREQ - 1);
            cnt         <= 4'd0;
            data_q      <= '0;
            resp_data   <= '0;
            resp_parity <= 1'b0;
            resp_id     <= '0;
        end else begin
            if (accept) begin
                data_q     <= core_din;
                last_grant <= grant;
                cnt        <= 4'(LAT - 1);
            end else if (state == S_BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (finish) begin
                resp_data   <= data_q;
                resp_parity <= core_par;
                resp_id     <= last_grant;
            end
        end
    end

    assign resp_valid = (state == S_DONE);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_parity_sched.sv
// Scoreboard bench for parity_sched: expected responses queued at drive time,
// popped on each response handshake; grant rotation and latency tracked alongside.
module tb_parity_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*8-1:0]   req_data = '0;
    logic [NREQ-1:0]     req_ready;
    logic                resp_valid;
    logic                resp_ready = 1'b1;
    logic [7:0]          resp_data;
    logic                resp_parity;
    logic [IDW-1:0]      resp_id;
    logic                busy;

    parity_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_parity (resp_parity),
        .resp_id     (resp_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     data;
        logic           par;
    } resp_t;

    resp_t           sb[$];
    resp_t           exp_r;
    logic [7:0]      pend[NREQ][$];
    logic [NREQ-1:0] acc_mask = '0;
    int              acc_hist[$];
    int              errors = 0;
    int              checks = 0;
    int              cyc = 0;
    int              mdl_last = NREQ - 1;
    int              g_exp;
    int              acc_cyc = 0;
    int              rdy0_cnt = 0;
    logic            prev_rv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_par(input logic [7:0] d);
`ifdef PARITY_ODD_EN
        return ~^d;
`else
        return ^d;
`endif
    endfunction

    function automatic int model_grant(input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(mdl_last + k) % NREQ]) return (mdl_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic expect_resp(input int id, input logic [7:0] d);
        sb.push_back('{id: IDW'(id), data: d, par: exp_par(d)});
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester drivers: present head of each queue, retire it once accepted.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i] && pend[i].size() > 0) void'(pend[i].pop_front());
        end
        acc_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = (pend[i].size() > 0);
            req_data[i*8 +: 8]   = (pend[i].size() > 0) ? pend[i][0] : 8'h00;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            mdl_last = NREQ - 1;
            prev_rv  = 1'b0;
        end else begin
            if (req_valid == '0) begin
                chk("ready_without_valid", 32'(req_ready), 32'd0);
            end else if (req_ready != '0) begin
                g_exp = model_grant(req_valid);
                chk("grant", 32'(req_ready), 32'd1 << g_exp);
                acc_mask = req_ready & req_valid;
                mdl_last = g_exp;
                acc_cyc  = cyc;
                acc_hist.push_back(cyc);
                if (req_ready[0]) rdy0_cnt++;
            end
            if (resp_valid && !prev_rv) chk("latency", 32'(cyc - acc_cyc), 32'(LAT + 1));
            prev_rv = resp_valid;
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(sb.size()), 32'd1);
                end else begin
                    exp_r = sb.pop_front();
                    chk("resp_id", 32'(resp_id), 32'(exp_r.id));
                    chk("resp_data", 32'(resp_data), 32'(exp_r.data));
                    chk("resp_parity", 32'(resp_parity), 32'(exp_r.par));
                end
            end
        end
    end

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n >= budget), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_resp_parity", 32'(resp_parity), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // All four requesters at once: strict rotation from requester 0.
        pend[0].push_back(8'hFD); pend[1].push_back(8'h0C);
        pend[2].push_back(8'h64); pend[3].push_back(8'hFF);
        expect_resp(0, 8'hFD); expect_resp(1, 8'h0C);
        expect_resp(2, 8'h64); expect_resp(3, 8'hFF);
        drain("t2_drain_timeout", 100);

        // Single requester 0: one-cycle ready pulse.
        rdy0_cnt = 0;
        pend[0].push_back(8'hFD);
        expect_resp(0, 8'hFD);
        drain("t1_drain_timeout", 50);
        chk("t1_ready0_cycles", 32'(rdy0_cnt), 32'd1);

        // Backpressure in DONE for five cycles, competing request pending.
        @(posedge clk); #2 resp_ready = 1'b0;
        pend[1].push_back(8'hA5);
        expect_resp(1, 8'hA5);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t3_wait_timeout", 32'(n >= 50), 32'd0);
        pend[3].push_back(8'h5A);
        expect_resp(3, 8'h5A);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("t3_hold_valid", 32'(resp_valid), 32'd1);
            chk("t3_hold_data", 32'(resp_data), 32'hA5);
            chk("t3_hold_id", 32'(resp_id), 32'd1);
            chk("t3_hold_parity", 32'(resp_parity), 32'(exp_par(8'hA5)));
            chk("t3_ready_low", 32'(req_ready), 32'd0);
            chk("t3_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #2 resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_valid_cleared", 32'(resp_valid), 32'd0);
        chk("t3_data_held", 32'(resp_data), 32'hA5);
        chk("t3_id_held", 32'(resp_id), 32'd1);
        drain("t3_drain_timeout", 50);

        // Persistent requester 2: re-granted every LAT+2 cycles.
        acc_hist.delete();
        pend[2].push_back(8'h01); pend[2].push_back(8'h80); pend[2].push_back(8'h3C);
        expect_resp(2, 8'h01); expect_resp(2, 8'h80); expect_resp(2, 8'h3C);
        drain("t5_drain_timeout", 100);
        chk("t5_accepts", 32'(acc_hist.size()), 32'd3);
        for (int k = 1; k < acc_hist.size(); k++) begin
            chk("t5_spacing", 32'(acc_hist[k] - acc_hist[k-1]), 32'(LAT + 2));
        end

        // Reset while 8'h64 is in flight.
        pend[0].push_back(8'h64);
        expect_resp(0, 8'h64);
        n = 0;
        while (!req_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_wait_timeout", 32'(n >= 50), 32'd0);
        @(posedge clk); #3;
        chk("t4_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_req_ready", 32'(req_ready), 32'd0);
        chk("t4_resp_valid", 32'(resp_valid), 32'd0);
        chk("t4_resp_data", 32'(resp_data), 32'd0);
        chk("t4_resp_id", 32'(resp_id), 32'd0);
        chk("t4_resp_parity", 32'(resp_parity), 32'd0);
        for (int i = 0; i < NREQ; i++) pend[i].delete();
        sb.delete();
        acc_mask = '0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        pend[1].push_back(8'h11); pend[0].push_back(8'h22);
        expect_resp(0, 8'h22); expect_resp(1, 8'h11);
        drain("t4_drain_timeout", 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
